// File: rtl/lcd_pkg.sv
// Shared constants for the LCD controllers: command opcodes, SPI word layout
// and refresh-sequencer state encodings.
package lcd_pkg;

    localparam int SPI_DATA_W = 10;
    localparam int SPI_A0_BIT = 8;

    localparam logic [7:0] LCD_CMD_PAGE = 8'hB0;
    localparam logic [7:0] LCD_CMD_COLH = 8'h10;
    localparam logic [7:0] LCD_CMD_COLL = 8'h00;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_CMD_PAGE = 4'd1;
    localparam logic [3:0] ST_CMD_COLH = 4'd2;
    localparam logic [3:0] ST_CMD_COLL = 4'd3;
    localparam logic [3:0] ST_RD_ADDR  = 4'd4;
    localparam logic [3:0] ST_RD_CAP   = 4'd5;
    localparam logic [3:0] ST_DATA     = 4'd6;
    localparam logic [3:0] ST_GAP      = 4'd7;
    localparam logic [3:0] ST_DONE     = 4'd8;

    function automatic logic [SPI_DATA_W-1:0] spi_word(input logic a0, input logic [7:0] byte_v);
        logic [SPI_DATA_W-1:0] w;
        w = {SPI_DATA_W{1'b0}};
        w[SPI_A0_BIT] = a0;
        w[7:0] = byte_v;
        return w;
    endfunction

endpackage

// File: rtl/lcd_frame_refresh_ctl.sv
// Full-screen refresh sequencer: per page, sends page/column address commands,
// then streams the page's frame-buffer bytes through the SPI write engine.
module lcd_frame_refresh_ctl
    import lcd_pkg::*;
#(
    parameter int PAGES      = 8,
    parameter int COLUMNS    = 128,
    parameter int COL_OFFSET = 0
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  Start_Sig,
    output logic                  Done_Sig,
    output logic                  Busy,
    output logic [9:0]            Ram_Addr,
    input  logic [7:0]            Ram_Data,
    output logic                  SPI_Start_Sig,
    output logic [SPI_DATA_W-1:0] SPI_Data,
    input  logic                  SPI_Done_Sig
);

    localparam logic [2:0] PAGE_LAST = 3'(PAGES - 1);
    localparam logic [6:0] COL_LAST  = 7'(COLUMNS - 1);
    localparam logic [7:0] COL_OFF   = 8'(COL_OFFSET);
    localparam logic [7:0] COLH_BYTE = LCD_CMD_COLH | {4'h0, COL_OFF[7:4]};
    localparam logic [7:0] COLL_BYTE = LCD_CMD_COLL | {4'h0, COL_OFF[3:0]};

    logic [3:0]            state_q, state_d;
    logic [3:0]            next_q, next_d;
    logic [2:0]            page_q, page_d;
    logic [6:0]            col_q, col_d;
    logic                  armed_q, armed_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  start_q, start_d;
    logic [SPI_DATA_W-1:0] data_q, data_d;
    logic [9:0]            addr_q, addr_d;

    // Next-state and output-register computation for the refresh FSM
    always_comb begin
        state_d = state_q;
        next_d  = next_q;
        page_d  = page_q;
        col_d   = col_q;
        armed_d = armed_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        start_d = start_q;
        data_d  = data_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                // Arming on a sampled low level gives one frame per Start assertion
                if (!Start_Sig) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    busy_d  = 1'b1;
                    page_d  = 3'd0;
                    col_d   = 7'd0;
                    next_d  = ST_CMD_PAGE;
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD_PAGE, ST_CMD_COLH, ST_CMD_COLL, ST_DATA: begin
                if (!start_q) begin
                    start_d = 1'b1;
                    case (state_q)
                        ST_CMD_PAGE: data_d = spi_word(1'b0, LCD_CMD_PAGE | {5'd0, page_q});
                        ST_CMD_COLH: data_d = spi_word(1'b0, COLH_BYTE);
                        ST_CMD_COLL: data_d = spi_word(1'b0, COLL_BYTE);
                        default:     data_d = data_q;
                    endcase
                end else if (SPI_Done_Sig) begin
                    start_d = 1'b0;
                    state_d = ST_GAP;
                    case (state_q)
                        ST_CMD_PAGE: next_d = ST_CMD_COLH;
                        ST_CMD_COLH: next_d = ST_CMD_COLL;
                        ST_CMD_COLL: next_d = ST_RD_ADDR;
                        default: begin
                            if (col_q < COL_LAST) begin
                                col_d  = col_q + 7'd1;
                                next_d = ST_RD_ADDR;
                            end else if (page_q < PAGE_LAST) begin
                                col_d  = 7'd0;
                                page_d = page_q + 3'd1;
                                next_d = ST_CMD_PAGE;
                            end else begin
                                next_d = ST_DONE;
                            end
                        end
                    endcase
                end else begin
                    start_d = 1'b1;
                end
            end
            ST_GAP: begin
                state_d = next_q;
                // Address goes out on entry to RD_ADDR so RAM data is ready in RD_CAP
                if (next_q == ST_RD_ADDR) begin
                    addr_d = {page_q, col_q};
                end else begin
                    addr_d = addr_q;
                end
            end
            ST_RD_ADDR: state_d = ST_RD_CAP;
            ST_RD_CAP: begin
                data_d  = spi_word(1'b1, Ram_Data);
                state_d = ST_DATA;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                armed_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                start_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            next_q  <= ST_IDLE;
            page_q  <= 3'd0;
            col_q   <= 7'd0;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            data_q  <= {SPI_DATA_W{1'b0}};
            addr_q  <= 10'd0;
        end else begin
            state_q <= state_d;
            next_q  <= next_d;
            page_q  <= page_d;
            col_q   <= col_d;
            armed_q <= armed_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    assign Done_Sig      = done_q;
    assign Busy          = busy_q;
    assign SPI_Start_Sig = start_q;
    assign SPI_Data      = data_q;
    assign Ram_Addr      = addr_q;

endmodule

// File: tb/tb_lcd_frame_refresh_ctl.sv
// Bench for lcd_frame_refresh_ctl: default and small configurations, SPI engine
// and frame-RAM models, with every write compared to a frame-level reference list.
module tb_lcd_frame_refresh_ctl;

    localparam int NI   = 2;
    localparam int MAXW = 2048;
    localparam int P_A = 8, C_A = 128, O_A = 0;
    localparam int P_B = 2, C_B = 3,   O_B = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_sig [NI];
    logic       spi_done  [NI];
    logic [7:0] ram_data  [NI];
    logic       done_o    [NI];
    logic       busy_o    [NI];
    logic       spi_start [NI];
    logic [9:0] ram_addr  [NI];
    logic [9:0] spi_data  [NI];

    logic [7:0] mem [NI][1024];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int lat_min [NI];
    int lat_max [NI];
    bit spur_en [NI];
    bit act     [NI];
    int rem     [NI];
    logic [9:0] wr_data [NI][MAXW];
    int wr_rise [NI][MAXW];
    int wr_done [NI][MAXW];
    int wr_n      [NI];
    int unstable  [NI];
    int done_cnt  [NI];
    int done_rise [NI];
    logic [9:0] exp_w [MAXW];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame-buffer RAM with one-cycle read latency
    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) ram_data[g] <= mem[g][ram_addr[g]];
    end

    lcd_frame_refresh_ctl #(.PAGES(P_A), .COLUMNS(C_A), .COL_OFFSET(O_A)) dut_a (
        .CLK(clk), .RSTn(rst_n), .Start_Sig(start_sig[0]), .Done_Sig(done_o[0]),
        .Busy(busy_o[0]), .Ram_Addr(ram_addr[0]), .Ram_Data(ram_data[0]),
        .SPI_Start_Sig(spi_start[0]), .SPI_Data(spi_data[0]), .SPI_Done_Sig(spi_done[0]));

    lcd_frame_refresh_ctl #(.PAGES(P_B), .COLUMNS(C_B), .COL_OFFSET(O_B)) dut_b (
        .CLK(clk), .RSTn(rst_n), .Start_Sig(start_sig[1]), .Done_Sig(done_o[1]),
        .Busy(busy_o[1]), .Ram_Addr(ram_addr[1]), .Ram_Data(ram_data[1]),
        .SPI_Start_Sig(spi_start[1]), .SPI_Data(spi_data[1]), .SPI_Done_Sig(spi_done[1]));

    task automatic check_eq(input string tag, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act_v, exp_v);
        end
    endtask

    // SPI write engine model: random-latency Done, optional spurious Done, write log
    initial begin
        for (int g = 0; g < NI; g++) begin
            spi_done[g] = 1'b0; act[g] = 1'b0; wr_n[g] = 0;
            lat_min[g] = 5; lat_max[g] = 5; spur_en[g] = 1'b0;
        end
        forever begin
            @(posedge clk); #1;
            for (int g = 0; g < NI; g++) begin
                spi_done[g] = 1'b0;
                if (!rst_n) begin
                    act[g] = 1'b0;
                end else begin
                    if (spi_start[g] && !act[g]) begin
                        act[g] = 1'b1;
                        rem[g] = $urandom_range(lat_max[g], lat_min[g]);
                        wr_data[g][wr_n[g]] = spi_data[g];
                        wr_rise[g][wr_n[g]] = cyc;
                    end
                    if (act[g]) begin
                        if (spi_data[g] !== wr_data[g][wr_n[g]] || !spi_start[g]) unstable[g]++;
                        rem[g]--;
                        if (rem[g] == 0) begin
                            spi_done[g] = 1'b1;
                            act[g] = 1'b0;
                            wr_done[g][wr_n[g]] = cyc;
                            if (wr_n[g] < MAXW - 1) wr_n[g]++;
                        end
                    end else if (spur_en[g] && !spi_start[g] && $urandom_range(3, 0) == 0) begin
                        spi_done[g] = 1'b1;
                    end
                    if (done_o[g]) begin
                        if (done_cnt[g] == 0) done_rise[g] = cyc;
                        done_cnt[g]++;
                    end
                end
            end
        end
    end

    task automatic check_idle_outputs(input int g, input string tag);
        check_eq({tag, "_done"}, done_o[g], 0);
        check_eq({tag, "_busy"}, busy_o[g], 0);
        check_eq({tag, "_start"}, spi_start[g], 0);
        check_eq({tag, "_data"}, spi_data[g], 0);
        check_eq({tag, "_addr"}, ram_addr[g], 0);
    endtask

    task automatic run_frame(input int g, input int lmin, input int lmax, input bit spur, input bit keep_high);
        int w, np, nc, off, nexp, gap_err, last, nchk, egap;
        np  = (g == 0) ? P_A : P_B;
        nc  = (g == 0) ? C_A : C_B;
        off = (g == 0) ? O_A : O_B;
        for (int a = 0; a < 1024; a++) mem[g][a] = 8'($urandom);
        lat_min[g] = lmin; lat_max[g] = lmax; spur_en[g] = spur;
        @(posedge clk); #1;
        start_sig[g] = 1'b0; wr_n[g] = 0; unstable[g] = 0; done_cnt[g] = 0;
        @(posedge clk); #1;
        start_sig[g] = 1'b1;
        @(posedge clk); #1;
        check_eq("accept_busy", busy_o[g], 1);
        check_eq("accept_nostart", spi_start[g], 0);
        @(posedge clk); #1;
        check_eq("gap_nostart", spi_start[g], 0);
        @(posedge clk); #1;
        check_eq("first_start", spi_start[g], 1);
        w = 0;
        while (!done_o[g] && w < 40000) begin
            @(posedge clk); #1;
            w++;
        end
        check_eq("done_seen", done_o[g], 1);
        check_eq("busy_with_done", busy_o[g], 1);
        @(posedge clk); #1;
        check_eq("done_pulse_end", done_o[g], 0);
        check_eq("busy_fall", busy_o[g], 0);
        repeat (3) @(posedge clk);
        #1;
        if (!keep_high) start_sig[g] = 1'b0;

        // Reference write list straight from the frame rules
        nexp = 0;
        for (int p = 0; p < np; p++) begin
            exp_w[nexp] = {2'b00, 8'hB0 + 8'(p)};       nexp++;
            exp_w[nexp] = {2'b00, 8'h10 + 8'(off / 16)}; nexp++;
            exp_w[nexp] = {2'b00, 8'(off % 16)};         nexp++;
            for (int c = 0; c < nc; c++) begin
                exp_w[nexp] = {2'b01, mem[g][p * 128 + c]};
                nexp++;
            end
        end
        check_eq("done_pulses", done_cnt[g], 1);
        last = (wr_n[g] > 0) ? wr_n[g] - 1 : 0;
        check_eq("done_latency", done_rise[g] - wr_done[g][last], 3);
        check_eq("nwrites", wr_n[g], nexp);
        nchk = (wr_n[g] < nexp) ? wr_n[g] : nexp;
        gap_err = 0;
        for (int i = 0; i < nchk; i++) begin
            check_eq($sformatf("write%0d", i), wr_data[g][i], exp_w[i]);
            if (i > 0) begin
                egap = exp_w[i][8] ? 5 : 3;
                if (wr_rise[g][i] - wr_done[g][i-1] != egap) gap_err++;
            end
        end
        check_eq("gaps", gap_err, 0);
        check_eq("stable", unstable[g], 0);
    endtask

    initial begin
        int w, n0, bhi;
        rst_n = 1'b0;
        for (int g = 0; g < NI; g++) start_sig[g] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs(0, "rst_a");
        check_idle_outputs(1, "rst_b");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_frame(0, 5, 5, 1'b0, 1'b0);
        run_frame(1, 5, 5, 1'b0, 1'b0);
        run_frame(0, 1, 20, 1'b1, 1'b0);

        // Start held high after Done must not produce a second frame
        run_frame(1, 1, 20, 1'b1, 1'b1);
        n0 = wr_n[1]; bhi = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (busy_o[1] || spi_start[1]) bhi++;
        end
        check_eq("no_rearm_busy", bhi, 0);
        check_eq("no_rearm_writes", wr_n[1], n0);
        run_frame(1, 1, 20, 1'b1, 1'b0);

        // Reset in the middle of page 3, then a clean restart
        lat_min[0] = 5; lat_max[0] = 5; spur_en[0] = 1'b0;
        @(posedge clk); #1;
        start_sig[0] = 1'b1;
        w = 0;
        while (!(busy_o[0] && ram_addr[0][9:7] == 3'd3) && w < 30000) begin
            @(posedge clk); #1;
            w++;
        end
        check_eq("reach_page3", (w < 30000), 1);
        repeat ($urandom_range(7, 0)) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle_outputs(0, "midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(0, 5, 5, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
